// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory controller slice.
// Contents: system sizes (NUM_CPUS, XLEN, CACHELINE_SIZE), READ_LAT / WBQ_DEPTH
// defaults, MEM_READ_LAT_MAX, crossbar/bus message structs, WBQ entry type,
// and a helper that classifies bus transactions that need a memory read.
package mem_ctrl_pkg;

  localparam int NUM_CPUS          = 4;
  localparam int CPU_W             = $clog2(NUM_CPUS);
  localparam int XLEN              = 4;
  localparam int CACHELINE_SIZE    = 8;
  localparam int MEM_READ_LAT_DEF  = 2;
  localparam int MEM_WBQ_DEPTH_DEF = 4;
  localparam int MEM_READ_LAT_MAX  = 8;

  typedef enum logic [2:0] {
    BusNone,
    BusGetS,
    BusGetM,
    BusUpgr,
    BusWb
  } bus_tx_t;

  typedef struct packed {
    logic                      valid;
    logic                      writeback;
    logic [CPU_W-1:0]          source;
    logic [CPU_W-1:0]          destination;
    logic [XLEN-1:0]           addr;
    logic [CACHELINE_SIZE-1:0] data;
  } xbar_msg_t;

  typedef struct packed {
    logic             valid;
    bus_tx_t          bus_tx;
    logic [CPU_W-1:0] source;
    logic [XLEN-1:0]  addr;
  } bus_msg_t;

  typedef struct packed {
    logic [XLEN-1:0]           addr;
    logic [CACHELINE_SIZE-1:0] data;
  } wbq_entry_t;

  function automatic logic is_read(bus_msg_t m);
    return m.valid && (m.bus_tx == BusGetS || m.bus_tx == BusGetM);
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Handshake/bus bundle between the requesters/bus and the memory controller.
// Signals: xbar_in (per-CPU writeback requests), wb_ack (one-hot accept),
// bus_msg (snooped bus transaction), xbar_out (read response), mem_busy.
// Modports: master = requester/bus side, slave = mem_ctrl.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  xbar_msg_t [NUM_CPUS-1:0] xbar_in;
  logic      [NUM_CPUS-1:0] wb_ack;
  bus_msg_t                 bus_msg;
  xbar_msg_t                xbar_out;
  logic                     mem_busy;

  modport master (
    output xbar_in,
    output bus_msg,
    input  wb_ack,
    input  xbar_out,
    input  mem_busy
  );

  modport slave (
    input  xbar_in,
    input  bus_msg,
    output wb_ack,
    output xbar_out,
    output mem_busy
  );
endinterface

// File: rtl/mem_ctrl_rr_arbiter.sv
// Round-robin arbiter for writeback requests.
// Ports: clk, rst (sync, active-high), en_i (grant permitted this cycle),
// req_i (request vector), gnt_o (combinational one-hot grant).
// Priority starts at the index after the last grant; pointer only moves on a grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && en_i && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = PW'((int'(idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: line storage, writeback queue (WBQ) and fixed-latency
// read pipeline.
// Ports: clk, rst (sync, active-high), mif (mem_ctrl_if.slave: xbar_in,
// wb_ack, bus_msg, xbar_out, mem_busy).
// Parameters: READ_LAT (1..MEM_READ_LAT_MAX), WBQ_DEPTH (power of 2, >= 2).
// Build option MEM_WB_FWD_EN: when defined, reads forward from the WBQ and the
// same-cycle writeback and mem_busy means WBQ full; otherwise reads use storage
// only and mem_busy covers any queued or just-granted writeback.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int READ_LAT  = MEM_READ_LAT_DEF,
  parameter int WBQ_DEPTH = MEM_WBQ_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  mif
);

  localparam int LINES = 2 ** XLEN;
  localparam int QW    = $clog2(WBQ_DEPTH);
  localparam int CW    = QW + 1;

  logic [CACHELINE_SIZE-1:0] mem_q [LINES];
  wbq_entry_t                wbq_q [WBQ_DEPTH];
  logic [QW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             cnt_q;
  xbar_msg_t                 pipe_q [READ_LAT];

  logic [NUM_CPUS-1:0]       req, gnt;
  logic                      wbq_full, wbq_empty, grant_vld, arb_en;
  wbq_entry_t                grant_entry;
  logic [CACHELINE_SIZE-1:0] rd_data;
  xbar_msg_t                 rsp_d;
  logic                      unused_bits;

  assign wbq_empty = (cnt_q == '0);
  assign wbq_full  = (cnt_q == CW'(WBQ_DEPTH));
  // Fullness is judged on the registered count so a same-cycle drain cannot open a slot.
  assign arb_en    = !wbq_full && !rst;

  always_comb begin
    req         = '0;
    unused_bits = 1'b0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      req[i]      = mif.xbar_in[i].valid && mif.xbar_in[i].writeback;
      unused_bits = unused_bits ^ (^{mif.xbar_in[i].source, mif.xbar_in[i].destination});
    end
  end

  rr_arbiter #(.N(NUM_CPUS)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (arb_en),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign mif.wb_ack = gnt;

  always_comb begin
    grant_vld   = |gnt;
    grant_entry = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (gnt[i]) begin
        grant_entry.addr = mif.xbar_in[i].addr;
        grant_entry.data = mif.xbar_in[i].data;
      end
    end
  end

`ifdef MEM_WB_FWD_EN
  logic [QW-1:0] fwd_idx;

  // Later overrides win: storage < same-cycle grant < WBQ entries, oldest to youngest.
  always_comb begin
    rd_data = mem_q[mif.bus_msg.addr];
    fwd_idx = '0;
    if (grant_vld && grant_entry.addr == mif.bus_msg.addr) rd_data = grant_entry.data;
    for (int k = 0; k < WBQ_DEPTH; k++) begin
      fwd_idx = QW'((int'(rd_ptr_q) + k) % WBQ_DEPTH);
      if (CW'(k) < cnt_q && wbq_q[fwd_idx].addr == mif.bus_msg.addr)
        rd_data = wbq_q[fwd_idx].data;
    end
  end

  assign mif.mem_busy = wbq_full;
`else
  assign rd_data      = mem_q[mif.bus_msg.addr];
  assign mif.mem_busy = !wbq_empty || grant_vld;
`endif

  always_comb begin
    rsp_d = '0;
    if (is_read(mif.bus_msg)) begin
      rsp_d.valid       = 1'b1;
      rsp_d.addr        = mif.bus_msg.addr;
      rsp_d.destination = mif.bus_msg.source;
      rsp_d.data        = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && grant_vld) wbq_q[wr_ptr_q] <= grant_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) mem_q[i] <= CACHELINE_SIZE'(i);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int s = 0; s < READ_LAT; s++) pipe_q[s] <= '0;
    end else begin
      if (!wbq_empty) begin
        mem_q[wbq_q[rd_ptr_q].addr] <= wbq_q[rd_ptr_q].data;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (grant_vld) wr_ptr_q <= wr_ptr_q + 1'b1;
      case ({grant_vld, !wbq_empty})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
      pipe_q[0] <= rsp_d;
      for (int s = 1; s < READ_LAT; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign mif.xbar_out = pipe_q[READ_LAT-1];

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a queue-based reference model predicts grants,
// mem_busy and read responses; a separate monitor checks xbar_out.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int READ_LAT  = MEM_READ_LAT_DEF;
  localparam int WBQ_DEPTH = MEM_WBQ_DEPTH_DEF;
  localparam int LINES     = 2 ** XLEN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if mif();

  mem_ctrl #(.READ_LAT(READ_LAT), .WBQ_DEPTH(WBQ_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  typedef struct { int addr; int dest; int data; int due; } exp_t;
  typedef struct { int addr; int data; } went_t;

  exp_t  sb[$];
  went_t wbq_m[$];
  int    mem_m [LINES];
  int    rr_next = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;

  logic [NUM_CPUS-1:0] ack_seen = '0;
  bit nw_v [NUM_CPUS];
  int nw_a [NUM_CPUS];
  int nw_d [NUM_CPUS];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) ack_seen = mif.wb_ack;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model, evaluated mid-cycle with this cycle's inputs stable.
  task automatic model_step();
    logic [NUM_CPUS-1:0] exp_ack;
    int    gidx;
    exp_t  e;
    went_t w;
    exp_ack = '0;
    gidx = -1;
    if (rst) begin
      check("wb_ack_in_rst", 64'(mif.wb_ack), 64'd0);
      for (int i = 0; i < LINES; i++) mem_m[i] = i;
      wbq_m.delete();
      rr_next = 0;
      for (int j = sb.size() - 1; j >= 0; j--)
        if (sb[j].due > cyc) sb.delete(j);
      return;
    end
    if (wbq_m.size() < WBQ_DEPTH) begin
      for (int k = 0; k < NUM_CPUS; k++) begin
        int i;
        i = (rr_next + k) % NUM_CPUS;
        if (gidx < 0 && mif.xbar_in[i].valid && mif.xbar_in[i].writeback) gidx = i;
      end
    end
    if (gidx >= 0) exp_ack[gidx] = 1'b1;
    check("wb_ack", 64'(mif.wb_ack), 64'(exp_ack));
`ifdef MEM_WB_FWD_EN
    check("mem_busy", 64'(mif.mem_busy), 64'(wbq_m.size() == WBQ_DEPTH));
`else
    check("mem_busy", 64'(mif.mem_busy), 64'(wbq_m.size() != 0 || gidx >= 0));
`endif
    if (mif.bus_msg.valid && (mif.bus_msg.bus_tx == BusGetS || mif.bus_msg.bus_tx == BusGetM)) begin
      e.addr = int'(mif.bus_msg.addr);
      e.dest = int'(mif.bus_msg.source);
      e.due  = cyc + READ_LAT;
      e.data = mem_m[e.addr];
`ifdef MEM_WB_FWD_EN
      if (gidx >= 0 && int'(mif.xbar_in[gidx].addr) == e.addr) e.data = int'(mif.xbar_in[gidx].data);
      foreach (wbq_m[j]) if (wbq_m[j].addr == e.addr) e.data = wbq_m[j].data;
`endif
      sb.push_back(e);
    end
    if (wbq_m.size() > 0) begin
      w = wbq_m.pop_front();
      mem_m[w.addr] = w.data;
    end
    if (gidx >= 0) begin
      w.addr = int'(mif.xbar_in[gidx].addr);
      w.data = int'(mif.xbar_in[gidx].data);
      wbq_m.push_back(w);
      rr_next = (gidx + 1) % NUM_CPUS;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  // Response monitor.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (mif.xbar_out.valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_latency", 64'(cyc), 64'(e.due));
          check("rsp_addr", 64'(mif.xbar_out.addr), 64'(e.addr));
          check("rsp_dest", 64'(mif.xbar_out.destination), 64'(e.dest));
          check("rsp_data", 64'(mif.xbar_out.data), 64'(e.data));
          check("rsp_wb", 64'(mif.xbar_out.writeback), 64'd0);
        end
      end else begin
        check("idle_zero", 64'(mif.xbar_out), 64'd0);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          check("missing_rsp", 64'(cyc), 64'(sb[0].due - 1));
          void'(sb.pop_front());
        end
      end
    end
  end

  // One call per clock: retire acked requests, install new ones, drive bus and rst.
  task automatic drive_cycle(input bit rd, input bus_tx_t tx, input int a, input int src, input bit r);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (ack_seen[i]) mif.xbar_in[i] = '0;
      if (nw_v[i] && !mif.xbar_in[i].valid) begin
        mif.xbar_in[i].valid     = 1'b1;
        mif.xbar_in[i].writeback = 1'b1;
        mif.xbar_in[i].source    = CPU_W'(i);
        mif.xbar_in[i].addr      = XLEN'(nw_a[i]);
        mif.xbar_in[i].data      = CACHELINE_SIZE'(nw_d[i]);
      end
      nw_v[i] = 1'b0;
    end
    rst = r;
    mif.bus_msg = '0;
    if (rd) begin
      mif.bus_msg.valid  = 1'b1;
      mif.bus_msg.bus_tx = tx;
      mif.bus_msg.source = CPU_W'(src);
      mif.bus_msg.addr   = XLEN'(a);
    end
    #1;
    if (mif.mem_busy) mif.bus_msg = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, BusNone, 0, 0, 1'b0);
  endtask

  initial begin
    logic [NUM_CPUS-1:0] pend;
    mif.xbar_in = '0;
    mif.bus_msg = '0;
    for (int i = 0; i < NUM_CPUS; i++) nw_v[i] = 1'b0;

    repeat (3) drive_cycle(1'b0, BusNone, 0, 0, 1'b1);
    drive_cycle(1'b1, BusGetS, 5, 2, 1'b0);
    idle(4);

    for (int i = 0; i < NUM_CPUS; i++) begin
      nw_v[i] = 1'b1; nw_a[i] = i; nw_d[i] = 8'hA0 + i;
    end
    idle(8);
    for (int a = 0; a < NUM_CPUS; a++) drive_cycle(1'b1, BusGetS, a, a, 1'b0);
    idle(4);

    nw_v[0] = 1'b1; nw_a[0] = 7; nw_d[0] = 8'h55;
    drive_cycle(1'b1, BusGetM, 7, 1, 1'b0);
    drive_cycle(1'b1, BusGetM, 7, 3, 1'b0);
    drive_cycle(1'b1, BusGetS, 7, 0, 1'b0);
    idle(4);

    for (int a = 1; a <= 3; a++) drive_cycle(1'b1, BusGetS, a, a, 1'b0);
    idle(4);
    drive_cycle(1'b1, BusGetS, 1, 1, 1'b0);
    drive_cycle(1'b1, BusGetS, 2, 2, 1'b1);
    drive_cycle(1'b1, BusGetS, 3, 3, 1'b1);
    for (int a = 0; a < 8; a++) drive_cycle(1'b1, BusGetS, a, a % NUM_CPUS, 1'b0);
    idle(4);

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_CPUS; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          nw_v[i] = 1'b1;
          nw_a[i] = int'($urandom_range(0, LINES - 1));
          nw_d[i] = int'($urandom_range(0, 255));
        end
      end
      drive_cycle(1'($urandom_range(0, 1)), bus_tx_t'($urandom_range(0, 4)),
                  int'($urandom_range(0, LINES - 1)), int'($urandom_range(0, NUM_CPUS - 1)),
                  1'($urandom_range(0, 99) == 0));
    end
    idle(12);

    pend = '0;
    for (int i = 0; i < NUM_CPUS; i++) pend[i] = mif.xbar_in[i].valid;
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("wb_reqs_drained", 64'(pend), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter READ_LAT, default 2, read response latency in cycles; legal range 1..8.
REQ-002 Parameter WBQ_DEPTH, default 4, writeback queue entries; power of 2, >=2.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 xbar_in  input  xbar_msg_t[NUM_CPUS]  per-CPU writeback requests (valid && writeback).
REQ-006 wb_ack  output  NUM_CPUS  one-hot; bit i high means xbar_in[i] writeback accepted this cycle.
REQ-007 bus_msg  input  bus_msg_t  snooped bus transaction; BusGetS/BusGetM trigger reads.
REQ-008 xbar_out  output  xbar_msg_t  read response to the requester; registered.
REQ-009 mem_busy  output  1  requesters and bus arbiter must throttle (meaning per REQ-024).

Function
REQ-010 Storage SHALL be 2**XLEN lines of CACHELINE_SIZE bits, indexed by addr.
REQ-011 Writeback request i SHALL be one with xbar_in[i].valid && xbar_in[i].writeback.
REQ-012 At most one writeback SHALL be accepted per cycle, granted round-robin starting after the last granted index; the pointer resets to 0.
REQ-013 wb_ack SHALL be combinational, asserted in the cycle the grant is made; requester holds its message stable until acked.
REQ-014 No grant SHALL be made when the WBQ is full at the start of the cycle, even if a drain occurs that cycle.
REQ-015 A granted writeback SHALL be enqueued {addr,data} at the next posedge.
REQ-016 When the WBQ is non-empty, the head entry SHALL be written to storage and dequeued every cycle; enqueue and dequeue in the same cycle leave the count unchanged.
REQ-017 WBQ pointers SHALL wrap modulo WBQ_DEPTH; the count SHALL be held in clog2(WBQ_DEPTH)+1 bits.
REQ-018 A bus_msg with valid and bus_tx in {BusGetS, BusGetM} sampled at edge T SHALL produce xbar_out.valid=1 for exactly one cycle after edge T+READ_LAT-1, i.e. visible READ_LAT cycles after issue.
REQ-019 Response fields SHALL be: addr=bus_msg.addr, destination=bus_msg.source, writeback=0, data captured at issue.
REQ-020 One read SHALL be accepted per cycle; back-to-back reads produce back-to-back responses in order.
REQ-021 Non-read bus transactions and invalid bus_msg SHALL produce no response.
REQ-022 When xbar_out.valid=0, all xbar_out fields SHALL be 0.

Reset
REQ-023 On rst: storage line i = CACHELINE_SIZE'(i); WBQ emptied (queued writebacks discarded); read pipeline invalidated (in-flight reads dropped); RR pointer=0; xbar_out all-zero; wb_ack=0 during rst.

Configuration
REQ-024 Macro MEM_WB_FWD_EN. Defined: read data SHALL be the youngest matching WBQ entry, else the writeback granted in the same cycle, else storage; mem_busy = WBQ full. Undefined: read data SHALL come from storage only; mem_busy = WBQ non-empty or a grant this cycle, and the bus arbiter must not issue reads while it is high.

Structure
REQ-025 READ_LAT/WBQ_DEPTH defaults, a wbq_entry_t {addr,data} typedef and MEM_READ_LAT_MAX SHALL live in package types alongside xbar_msg_t/bus_msg_t.
REQ-026 The round-robin writeback arbiter SHALL be a sub-module rr_arbiter (NUM_CPUS requests, one-hot grant, advance-on-grant).

Verification
REQ-027 Read after reset: BusGetS addr=5, source=2 at T -> xbar_out valid at T+2 (READ_LAT=2), data=5, destination=2.
REQ-028 All CPUs write back simultaneously (NUM_CPUS=4, addr=i, data=0xA0+i) -> grants 0,1,2,3 on consecutive cycles; later reads return 0xA0+i.
REQ-029 Fill WBQ (4 entries, drain in progress) -> no ack while full; 5th acked the cycle after the count drops below 4.
REQ-030 MEM_WB_FWD_EN defined: writeback addr=7 data=0x55 queued, BusGetM addr=7 same cycle as enqueue -> response data=0x55; undefined -> mem_busy=1 until WBQ empty.
REQ-031 Reads at T, T+1, T+2 to addrs 1,2,3 -> responses on three consecutive cycles, in order; rst asserted at T+1 -> no responses, storage reinitialised.
